draw_line_arb: RTL
==================

# draw_line_arb

Round-robin arbiter and sequencer that shares a single `draw_line` engine between `REQN` independent shape renderers (cube, triangle, UI overlay, etc.). Each requester offers one line at a time over a valid/ready handshake. The block latches the winning line's coordinates and colour, pulses the engine start, and waits for the engine's done. It then returns a per-requester completion pulse. It sits between the render modules and the one `draw_line` instance feeding the framebuffer writer.

## Interface
- `CORDW`, 16: signed coordinate width (bits)
- `CIDXW`, 4: colour index width (bits)
- `REQN`, 2: number of requesters, legal range 2..4
- `IDW`, derived `$clog2(REQN)`: grant identifier width
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in REQN: requester i has a line pending
- `req_ready` out REQN: one-hot accept strobe; line i is taken when `req_valid[i] && req_ready[i]`
- `req_x0`, `req_y0`, `req_x1`, `req_y1` in REQN*CORDW: packed signed coordinates; requester i occupies `[i*CORDW +: CORDW]`
- `req_cidx` in REQN*CIDXW: packed colour index, same slicing with CIDXW
- `line_done` out REQN: one-cycle pulse to the requester whose line just finished
- `eng_start` out 1: one-cycle start pulse to the engine
- `eng_x0`, `eng_y0`, `eng_x1`, `eng_y1` out CORDW: registered coordinates to the engine
- `eng_cidx` out CIDXW: registered colour index for the pixel writer
- `eng_done` in 1: engine completion pulse
- `grant_id` out IDW: index of the current or last owner
- `busy` out 1: high in any state other than IDLE

## Operation
- States: IDLE, START, WAIT.
- **IDLE:**
  - Select a winner among asserted `req_valid`. Search starts at `last+1` and wraps modulo REQN.
  - `req_ready` is combinational: it is one-hot on the winner, and only while in IDLE.
  - On acceptance:
    - Latch the winner's coords and cidx into the `eng_*` regs.
    - Set `grant_id` and `last` to the winner.
    - Go to START.
  - If no request is valid, stay in IDLE with `req_ready` all zero.
- **START:** `eng_start`=1 for this cycle only. Go to WAIT.
- **WAIT:** on `eng_done`, `line_done[grant_id]`=1 for the next cycle and go to IDLE.
- `eng_done` outside WAIT is ignored.
- Requesters must hold `req_valid` and their data stable until accepted. Coordinates are sampled only on the accept cycle; changes afterwards do not affect the line in flight.
- A requester may re-assert or keep `req_valid` for its next line. Round-robin prevents it from winning twice while another requester is waiting.
- No coordinate arithmetic: the `eng_*` fields are passed through unchanged at full CORDW/CIDXW width, signedness preserved.

## Timing
- Reset values:
  - State is IDLE.
  - `eng_start`=0, `line_done`=0, `busy`=0.
  - `eng_x0`, `eng_y0`, `eng_x1`, `eng_y1` and `eng_cidx` are 0.
  - `grant_id`=0.
  - `last`=REQN-1, so requester 0 wins first.
- Accept on cycle N gives `eng_start`=1 on cycle N+1 and WAIT from N+2.
- `eng_done` on cycle M gives `line_done` and IDLE on M+1. A new accept is possible on M+1, so the minimum gap between engine lines is 2 cycles plus the engine time.
- `req_ready` is low in START and WAIT, including the `eng_done` cycle.
- Reset asserted mid-line:
  - The block returns immediately to IDLE.
  - No `line_done` is issued.
  - The engine shares `rst_n` and aborts too.
- Simultaneous `req_valid` from all requesters: grants rotate strictly 0,1,..,REQN-1,0.

## Configuration
- `DRAW_LINE_ARB_FIXED_PRI_EN`:
  - Defined: fixed priority, where the lowest asserted index always wins and `last` is unused.
  - Undefined (default): round-robin as above.
- Handshake, latency and reset behaviour are identical in both modes.

## Test plan
- **Reset then single request:** requester 1 offers (10,20)->(30,40), cidx 'h3. Required:
  - `req_ready[1]` pulses in the same cycle.
  - `eng_start` follows 1 cycle later with `eng_x0`=10, `eng_y1`=40, `eng_cidx`=3.
  - `line_done[1]` appears 1 cycle after `eng_done`.
- **Round-robin fairness:** REQN=3, all valid continuously for 6 lines. Required grant order is 0,1,2,0,1,2 and `busy` stays high except for the IDLE accept cycles.
- **Fixed priority** (macro defined): same stimulus as round-robin fairness gives grants 0,0,0,0,0,0 while requester 0 stays valid. Dropping `req_valid[0]` makes requester 1 win next.
- **Data stability:** change requester 0's coords to (-5,-5)->(7,7) during WAIT. Required:
  - The `eng_*` fields keep the originally accepted values.
  - The next line uses (-5,-5)->(7,7) with sign preserved.
- **Reset mid-line:** pull `rst_n` low during WAIT. Required:
  - All outputs go to their reset values asynchronously.
  - No `line_done` is produced.
  - After release, requester 0 wins first.
- **Spurious done:** pulse `eng_done` in IDLE and in START. Required: no `line_done` and no state change other than the normal START->WAIT advance.

Source files
------------

// File: rtl/draw_line_arb_if.sv
// rtl/draw_line_arb_if.sv - requester and engine bundle shared by draw_line_arb and its neighbours
interface draw_line_arb_if #(
  parameter int CORDW = 16,
  parameter int CIDXW = 4,
  parameter int REQN  = 2,
  parameter int IDW   = $clog2(REQN)
) ();
  logic        [REQN-1:0]       req_valid;
  logic        [REQN-1:0]       req_ready;
  logic        [REQN*CORDW-1:0] req_x0;
  logic        [REQN*CORDW-1:0] req_y0;
  logic        [REQN*CORDW-1:0] req_x1;
  logic        [REQN*CORDW-1:0] req_y1;
  logic        [REQN*CIDXW-1:0] req_cidx;
  logic        [REQN-1:0]       line_done;
  logic                         eng_start;
  logic signed [CORDW-1:0]      eng_x0;
  logic signed [CORDW-1:0]      eng_y0;
  logic signed [CORDW-1:0]      eng_x1;
  logic signed [CORDW-1:0]      eng_y1;
  logic        [CIDXW-1:0]      eng_cidx;
  logic                         eng_done;
  logic        [IDW-1:0]        grant_id;
  logic                         busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_x0, req_y0, req_x1, req_y1, req_cidx, eng_done,
    output req_ready, line_done, eng_start, eng_x0, eng_y0, eng_x1, eng_y1,
    output eng_cidx, grant_id, busy
  );

  // Requesters plus engine, as seen from outside the arbiter
  modport master (
    output req_valid, req_x0, req_y0, req_x1, req_y1, req_cidx, eng_done,
    input  req_ready, line_done, eng_start, eng_x0, eng_y0, eng_x1, eng_y1,
    input  eng_cidx, grant_id, busy
  );
endinterface

// File: rtl/draw_line_arb.sv
// rtl/draw_line_arb.sv - shares one draw_line engine between REQN renderers, round-robin by default
// Define DRAW_LINE_ARB_FIXED_PRI_EN for fixed priority (lowest asserted index wins).
module draw_line_arb #(
  parameter int  CORDW = 16,
  parameter int  CIDXW = 4,
  parameter int  REQN  = 2,
  localparam int IDW   = $clog2(REQN)
) (
  input  logic            clk,
  input  logic            rst_n,
  draw_line_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic        [IDW-1:0]   grant_id_q, grant_id_d;
  logic signed [CORDW-1:0] eng_x0_q, eng_x0_d;
  logic signed [CORDW-1:0] eng_y0_q, eng_y0_d;
  logic signed [CORDW-1:0] eng_x1_q, eng_x1_d;
  logic signed [CORDW-1:0] eng_y1_q, eng_y1_d;
  logic        [CIDXW-1:0] eng_cidx_q, eng_cidx_d;
  logic        [REQN-1:0]  line_done_q, line_done_d;

  logic                    win_vld;
  logic        [IDW-1:0]   win_id;
  logic                    accept;

`ifdef DRAW_LINE_ARB_FIXED_PRI_EN
  // Scan downwards so the lowest asserted index is the last writer
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int i = REQN - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win_vld = 1'b1;
        win_id  = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] last_q, last_d;

  // Search starts just past the previous owner and wraps, so a busy requester yields
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = 1; k <= REQN; k++) begin
      if (!win_vld && bus.req_valid[(int'(last_q) + k) % REQN]) begin
        win_vld = 1'b1;
        win_id  = IDW'((int'(last_q) + k) % REQN);
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (accept) begin
      last_d = win_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDW'(REQN - 1);
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign accept = (state_q == ST_IDLE) && win_vld;

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    eng_x0_d    = eng_x0_q;
    eng_y0_d    = eng_y0_q;
    eng_x1_d    = eng_x1_q;
    eng_y1_d    = eng_y1_q;
    eng_cidx_d  = eng_cidx_q;
    line_done_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          eng_x0_d   = bus.req_x0[int'(win_id)*CORDW +: CORDW];
          eng_y0_d   = bus.req_y0[int'(win_id)*CORDW +: CORDW];
          eng_x1_d   = bus.req_x1[int'(win_id)*CORDW +: CORDW];
          eng_y1_d   = bus.req_y1[int'(win_id)*CORDW +: CORDW];
          eng_cidx_d = bus.req_cidx[int'(win_id)*CIDXW +: CIDXW];
          grant_id_d = win_id;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // eng_done is only honoured here; elsewhere it is a stray pulse
        if (bus.eng_done) begin
          line_done_d = REQN'(1) << grant_id_q;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      eng_x0_q    <= '0;
      eng_y0_q    <= '0;
      eng_x1_q    <= '0;
      eng_y1_q    <= '0;
      eng_cidx_q  <= '0;
      line_done_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      eng_x0_q    <= eng_x0_d;
      eng_y0_q    <= eng_y0_d;
      eng_x1_q    <= eng_x1_d;
      eng_y1_q    <= eng_y1_d;
      eng_cidx_q  <= eng_cidx_d;
      line_done_q <= line_done_d;
    end
  end

  assign bus.req_ready = accept ? (REQN'(1) << win_id) : '0;
  assign bus.eng_start = (state_q == ST_START);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.grant_id  = grant_id_q;
  assign bus.eng_x0    = eng_x0_q;
  assign bus.eng_y0    = eng_y0_q;
  assign bus.eng_x1    = eng_x1_q;
  assign bus.eng_y1    = eng_y1_q;
  assign bus.eng_cidx  = eng_cidx_q;
  assign bus.line_done = line_done_q;

endmodule
